// File: rtl/fp_unpack.sv
// fp_unpack
//   Unpacks an IEEE-754 single-precision operand into sign, unbiased
//   exponent, significand with explicit leading bit, and a one-hot class.
//   A valid/ready handshake is used on both sides, and a result is held
//   until the consumer takes it.
//
//   Optional feature: define FP_UNPACK_NORM_EN to normalise subnormal
//   operands with a 1-bit-per-cycle shifter (adds the NORM state). Without
//   it, subnormals are reported un-normalised with exponent -126.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_data valid
//   in_ready   block can accept an operand
//   in_data    operand {sign, exponent[7:0], fraction[22:0]}
//   out_valid  unpacked result valid
//   out_ready  consumer accepts result
//   sign       operand sign
//   exp_unb    unbiased exponent, two's complement (-149..+128)
//   mant       significand with explicit leading bit
//   is_zero, is_sub, is_norm, is_inf, is_qnan, is_snan  one-hot class flags
module fp_unpack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign,
  output logic [8:0]  exp_unb,
  output logic [23:0] mant,
  output logic        is_zero,
  output logic        is_sub,
  output logic        is_norm,
  output logic        is_inf,
  output logic        is_qnan,
  output logic        is_snan
);

`ifdef FP_UNPACK_NORM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, NORM = 2'd1, HOLD = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd2} state_t;
`endif

  // Flag vector order matches {is_zero, is_sub, is_norm, is_inf, is_qnan, is_snan}.
  localparam logic [5:0] F_ZERO = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b010000;
  localparam logic [5:0] F_NORM = 6'b001000;
  localparam logic [5:0] F_INF  = 6'b000100;
  localparam logic [5:0] F_QNAN = 6'b000010;
  localparam logic [5:0] F_SNAN = 6'b000001;

  localparam logic [8:0] EXP_SPECIAL = 9'h080;  // +128
  localparam logic [8:0] EXP_SUB     = 9'h182;  // -126

  state_t      state;
  logic [5:0]  flags;
  logic        accept;
  logic [7:0]  e;
  logic [22:0] f;
  logic [8:0]  c_exp;
  logic [23:0] c_mant;
  logic [5:0]  c_flags;

  assign e = in_data[30:23];
  assign f = in_data[22:0];

  // A waiting result may be replaced on the same edge it is consumed,
  // so HOLD only accepts when the consumer is also taking the result.
  assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept   = in_valid && in_ready;

  assign {is_zero, is_sub, is_norm, is_inf, is_qnan, is_snan} = flags;

  // Classify the incoming operand and form the fields it will be loaded with.
  always_comb begin
    c_exp   = 9'd0;
    c_mant  = 24'd0;
    c_flags = F_NORM;
    if (e == 8'hFF) begin
      c_exp  = EXP_SPECIAL;
      c_mant = {1'b0, f};
      if (f == 23'd0)
        c_flags = F_INF;
      else if (f[22])
        c_flags = F_QNAN;
      else
        c_flags = F_SNAN;
    end else if (e == 8'd0) begin
      if (f == 23'd0) begin
        c_flags = F_ZERO;
      end else begin
        c_flags = F_SUB;
        c_exp   = EXP_SUB;
        c_mant  = {1'b0, f};
      end
    end else begin
      c_exp  = {1'b0, e} - 9'd127;
      c_mant = {1'b1, f};
    end
  end

  // Main FSM. Flags stay clear until the result is actually presented, so a
  // subnormal being normalised shows no class until it reaches HOLD.
  // In NORM the transition to HOLD happens on the same edge as the shift that
  // brings the leading one into bit 23, which gives latency 1 + leading zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      sign      <= 1'b0;
      exp_unb   <= 9'd0;
      mant      <= 24'd0;
      flags     <= 6'd0;
    end else if (accept) begin
      sign    <= in_data[31];
      exp_unb <= c_exp;
      mant    <= c_mant;
`ifdef FP_UNPACK_NORM_EN
      if (c_flags == F_SUB) begin
        state     <= NORM;
        out_valid <= 1'b0;
        flags     <= 6'd0;
      end else begin
`else
      begin
`endif
        state     <= HOLD;
        out_valid <= 1'b1;
        flags     <= c_flags;
      end
    end else begin
      case (state)
`ifdef FP_UNPACK_NORM_EN
        NORM: begin
          mant    <= mant << 1;
          exp_unb <= exp_unb - 9'd1;
          if (mant[22]) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            flags     <= F_SUB;
          end
        end
`endif
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            flags     <= 6'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_unpack.sv
// tb_fp_unpack
//   Directed bench for fp_unpack. Expected results come from a behavioural
//   model and are queued when an operand is driven; a checker process pops
//   and compares each result when it is handed over to the consumer.
//   Builds with or without FP_UNPACK_NORM_EN, matching the DUT build.
module tb_fp_unpack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        sign;
  logic [8:0]  exp_unb;
  logic [23:0] mant;
  logic        is_zero, is_sub, is_norm, is_inf, is_qnan, is_snan;
  logic [5:0]  flags;

  typedef struct packed {
    logic        sign;
    logic [8:0]  exp;
    logic [23:0] mant;
    logic [5:0]  flags;
  } res_t;

  res_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  assign flags = {is_zero, is_sub, is_norm, is_inf, is_qnan, is_snan};

  fp_unpack dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign      (sign),
    .exp_unb   (exp_unb),
    .mant      (mant),
    .is_zero   (is_zero),
    .is_sub    (is_sub),
    .is_norm   (is_norm),
    .is_inf    (is_inf),
    .is_qnan   (is_qnan),
    .is_snan   (is_snan)
  );

  always #5 clk = ~clk;

  // Leading zeros of the 24-bit value {0, f}, for f != 0.
  function automatic int lead_zeros(input logic [22:0] f);
    for (int i = 22; i >= 0; i--)
      if (f[i]) return 23 - i;
    return 24;
  endfunction

  // Reference model of one unpacked result.
  function automatic res_t model(input logic [31:0] d);
    res_t        r;
    int          ex;
    int          lz;
    logic [7:0]  e;
    logic [22:0] f;
    e       = d[30:23];
    f       = d[22:0];
    r.sign  = d[31];
    if (e == 8'd255) begin
      r.exp   = 9'd128;
      r.mant  = {1'b0, f};
      r.flags = (f == 23'd0) ? 6'b000100 : (f[22] ? 6'b000010 : 6'b000001);
    end else if (e == 8'd0 && f == 23'd0) begin
      r.exp   = 9'd0;
      r.mant  = 24'd0;
      r.flags = 6'b100000;
    end else if (e == 8'd0) begin
      r.flags = 6'b010000;
`ifdef FP_UNPACK_NORM_EN
      lz      = lead_zeros(f);
      ex      = -126 - lz;
      r.mant  = {1'b0, f} << lz;
`else
      lz      = 0;
      ex      = -126;
      r.mant  = {1'b0, f};
`endif
      r.exp   = ex[8:0];
    end else begin
      ex      = int'(e) - 127;
      r.exp   = ex[8:0];
      r.mant  = {1'b1, f};
      r.flags = 6'b001000;
    end
    return r;
  endfunction

  function automatic int exp_latency(input logic [31:0] d);
`ifdef FP_UNPACK_NORM_EN
    if (d[30:23] == 8'd0 && d[22:0] != 23'd0) return 1 + lead_zeros(d[22:0]);
`endif
    return 1;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one operand, queue its expected result and wait for the accept edge.
  // Returns just after the accepting edge; waits counts extra cycles needed.
  task automatic apply_stimulus(input logic [31:0] d, output int waits);
    in_valid = 1'b1;
    in_data  = d;
    sb.push_back(model(d));
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 60) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) check_output("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drop_valid();
    in_valid = 1'b0;
    in_data  = 32'h0;
  endtask

  // Called just after an accept edge: measure cycles until out_valid.
  task automatic wait_valid(input int exp_lat, input string tag);
    int lat;
    lat = 1;
    while (!out_valid && lat < 40) begin
      check_output({tag, "_busy_in_ready"}, in_ready, 0);
      @(posedge clk);
      #1;
      lat++;
    end
    check_output({tag, "_latency"}, lat, exp_lat);
  endtask

  // Scoreboard checker: compare each result on the cycle it is consumed, and
  // make sure no class flag shows while nothing is presented.
  always @(negedge clk) begin
    res_t r;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_output("unexpected_result", out_valid, 0);
      end else begin
        r = sb.pop_front();
        check_output("result", {sign, exp_unb, mant, flags}, r);
      end
    end
    if (rst_n && !out_valid) check_output("flags_idle", flags, 0);
  end

  initial begin
    int w;
    logic [31:0] d;
    logic [31:0] edge_ops [6];
    edge_ops = '{32'h00400000, 32'h007FFFFF, 32'h00800000, 32'h7F7FFFFF,
                 32'h80000001, 32'h3F000000};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_in_ready",  in_ready,  1);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_fields", {sign, exp_unb, mant, flags}, 40'd0);
    rst_n = 1'b1;

    // 1.0: accepted on the first edge after reset release
    apply_stimulus(32'h3F800000, w);
    check_output("first_accept_waits", w, 0);
    drop_valid();
    check_output("one_out_valid", out_valid, 1);
    check_output("one_fields", {sign, exp_unb, mant, is_norm}, {1'b0, 9'd0, 24'h800000, 1'b1});
    wait_valid(1, "one");

    // Smallest subnormal
    apply_stimulus(32'h00000001, w);
    drop_valid();
`ifdef FP_UNPACK_NORM_EN
    wait_valid(24, "min_sub");
    check_output("min_sub_fields", {exp_unb, mant, is_sub}, {9'h16B, 24'h800000, 1'b1});
`else
    wait_valid(1, "min_sub");
    check_output("min_sub_fields", {exp_unb, mant, is_sub}, {9'h182, 24'h000001, 1'b1});
`endif

    // Boundary operands around the subnormal/normal/overflow edges
    foreach (edge_ops[i]) begin
      apply_stimulus(edge_ops[i], w);
      drop_valid();
      wait_valid(exp_latency(edge_ops[i]), "edge");
    end
    @(posedge clk);
    #1;

    // Special values back-to-back
    apply_stimulus(32'h7FC00000, w);
    check_output("b2b0_waits", w, 0);
    check_output("b2b0_qnan", is_qnan, 1);
    apply_stimulus(32'h7F800001, w);
    check_output("b2b1_waits", w, 0);
    check_output("b2b1_snan", is_snan, 1);
    apply_stimulus(32'hFF800000, w);
    check_output("b2b2_waits", w, 0);
    check_output("b2b2_inf", {is_inf, sign, exp_unb}, {1'b1, 1'b1, 9'd128});
    apply_stimulus(32'h80000000, w);
    check_output("b2b3_waits", w, 0);
    check_output("b2b3_zero", {is_zero, sign}, {1'b1, 1'b1});
    drop_valid();
    @(posedge clk);
    #1;

    // Back-pressure: result held, junk on in_data ignored, released into a new accept
    out_ready = 1'b0;
    apply_stimulus(32'hC0490FDB, w);
    in_valid = 1'b1;
    in_data  = 32'hFFFFFFFF;
    repeat (3) begin
      check_output("hold_fields", {out_valid, sign, exp_unb, mant, is_norm},
                   {1'b1, 1'b1, 9'd1, 24'hC90FDB, 1'b1});
      check_output("hold_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    apply_stimulus(32'h3F800000, w);
    check_output("release_waits", w, 0);
    drop_valid();
    @(posedge clk);
    #1;

    // Reset in the middle of an operation discards it
    out_ready = 1'b0;
    apply_stimulus(32'h00000400, w);
    drop_valid();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check_output("abort_out_valid", out_valid, 0);
    check_output("abort_in_ready",  in_ready,  1);
    check_output("abort_fields", {sign, exp_unb, mant, flags}, 40'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      check_output("abort_no_result", out_valid, 0);
    end
    apply_stimulus(32'h3F800000, w);
    check_output("after_abort_waits", w, 0);
    drop_valid();
    check_output("after_abort_fields", {out_valid, exp_unb, mant, is_norm},
                 {1'b1, 9'd0, 24'h800000, 1'b1});
    wait_valid(1, "after_abort");

    // Random operands with biased exponent classes
    for (int k = 0; k < 12; k++) begin
      d = $urandom;
      case ($urandom_range(0, 3))
        1: d[30:23] = 8'd0;
        2: d[30:23] = 8'd255;
        default: ;
      endcase
      apply_stimulus(d, w);
      drop_valid();
      wait_valid(exp_latency(d), "rand");
    end

    repeat (3) @(posedge clk);
    #1;
    check_output("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_unpack.md
FP_UNPACK -- requirements
Module: fp_unpack

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Ports SHALL be, in order:
- clk  in  1  – sole clock, rising edge.
- rst_n  in  1  – asynchronous active-low reset.
- in_valid  in  1  – in_data valid.
- in_ready  out  1  – block can accept an operand.
- in_data  in  32  – IEEE-754 single-precision operand {sign, exponent[7:0], fraction[22:0]}.
- out_valid  out  1  – unpacked result valid.
- out_ready  in  1  – consumer accepts result.
- sign  out  1  – operand sign.
- exp_unb  out  9  – unbiased exponent, two's complement.
- mant  out  24  – significand with explicit leading bit.
- is_zero, is_sub, is_norm, is_inf, is_qnan, is_snan  out  1 each  – one-hot class flags.

Function
REQ-003 A transfer SHALL occur on a rising edge where valid and ready are both high, on either side.
REQ-004 The FSM SHALL have three states: IDLE, NORM and HOLD.
REQ-005 in_ready SHALL be high in IDLE, and in HOLD when out_ready is high; it SHALL be low in NORM.
REQ-006 On accept, the block SHALL register the fields and classify the operand by e = in_data[30:23] and f = in_data[22:0]:
- e=0, f=0 → zero.
- e=0, f≠0 → subnormal.
- e=255, f=0 → inf.
- e=255, f[22]=1 → qnan.
- e=255, f[22]=0, f≠0 → snan.
- otherwise → normal.
REQ-007 Class outputs SHALL be:
- normal: exp_unb = e−127, mant = {1,f}.
- zero: exp_unb = 0, mant = 0.
- inf/NaN: exp_unb = +128, mant = {0,f}.
REQ-008 Non-subnormal operands SHALL go to HOLD; out_valid SHALL rise on the edge after accept (latency 1).
REQ-009 Subnormal handling (normalization compiled in):
- On accept, enter NORM with mant = {0,f} and exp_unb = −126.
- In NORM, each cycle, shift mant left by 1 and decrement exp_unb by 1 until mant[23] = 1, then go to HOLD.
- Latency SHALL be 1 + the leading-zero count of {0,f}, in the range 2..24 cycles.
REQ-010 In HOLD, all outputs SHALL be stable while out_valid=1 and out_ready=0.
REQ-011 In HOLD with out_ready=1:
- If in_valid=1, the next operand SHALL be accepted on the same edge (back-to-back, no bubble).
- Otherwise the FSM SHALL return to IDLE and out_valid SHALL fall.
REQ-012 exp_unb SHALL stay within −149..+128; the 9-bit field SHALL never wrap.
REQ-013 Exactly one class flag SHALL be high while out_valid=1; all flags SHALL be 0 while out_valid=0.
REQ-014 in_data SHALL be ignored whenever in_ready=0.

Reset
REQ-015 While rst_n=0 the block SHALL be held in reset, with the following values:
- state = IDLE, in_ready = 1, out_valid = 0.
- sign = 0, exp_unb = 0, mant = 0, all flags = 0.
REQ-016 Reset asserted in NORM or HOLD SHALL abort the operation immediately; the in-flight result SHALL be discarded and never presented.
REQ-017 After rst_n deassertion, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-018 The macro FP_UNPACK_NORM_EN SHALL select subnormal handling:
- Defined: NORM state and shifter are present, and REQ-009 applies.
- Undefined: no NORM state; a subnormal goes directly to HOLD with mant = {0,f}, exp_unb = −126, is_sub = 1, latency 1.

Verification
REQ-019 0x3F800000 accepted → next edge: out_valid=1, sign=0, exp_unb=0, mant=0x800000, is_norm=1.
REQ-020 0x00000001 with FP_UNPACK_NORM_EN → out_valid after 24 cycles, exp_unb=0x16B (−149), mant=0x800000, is_sub=1; without the macro → after 1 cycle, exp_unb=0x182 (−126), mant=0x000001.
REQ-021 Sequence 0x7FC00000, 0x7F800001, 0xFF800000, 0x80000000 with out_ready=1 → results on 4 consecutive cycles:
- is_qnan.
- is_snan.
- is_inf with sign=1, exp_unb=+128.
- is_zero with sign=1.
REQ-022 0xC0490FDB accepted with out_ready=0 for 3 cycles → outputs held stable (sign=1, exp_unb=1, mant=0xC90FDB) and in_ready=0; out_ready=1 → released, next operand accepted on the same edge.
REQ-023 0x00000400 accepted, rst_n pulsed low during NORM → out_valid stays 0, state returns to IDLE, and the next operand 0x3F800000 completes per REQ-019.
